cache_fill_ctrl: RTL



---
 rtl/cache_pkg.sv | 27 ++
 rtl/fixed_prio_arbiter.sv | 25 ++
 rtl/cache_fill_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill engine: fill-state encoding, default
// geometry and a constant-evaluable ceil(log2) helper.
package cache_pkg;

    localparam int DEF_ADDR_W          = 16;
    localparam int DEF_DATA_W          = 16;
    localparam int DEF_WORDS_PER_BLOCK = 8;
    localparam int DEF_MEM_LATENCY     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fixed_prio_arbiter.sv
// Combinational fixed-priority arbiter: the lowest set request index wins,
// and the grant is one-hot (all zero when nothing is requested).
module fixed_prio_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    // blocked[i] is set when any lower index is requesting
    logic [NUM_REQ-1:0] blocked;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign blocked[gi] = 1'b0;
            end else begin : g_rest
                assign blocked[gi] = blocked[gi-1] | req[gi-1];
            end
            assign grant[gi] = req[gi] & ~blocked[gi];
        end
    endgenerate

endmodule

// File: rtl/cache_fill_ctrl.sv
// Multi-requester cache-miss fill engine: arbitrates misses, issues pipelined
// word reads for the whole block, streams returns into the data array, writes the tag.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int NUM_REQ         = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 miss_req,
    input  logic [NUM_REQ*ADDR_W-1:0]          miss_addr,
    output logic                               stall,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic                               mem_data_valid,
    input  logic [DATA_W-1:0]                  mem_data_in,
    output logic                               data_wr,
    output logic [clog2(WORDS_PER_BLOCK)-1:0]  data_wr_word,
    output logic [DATA_W-1:0]                  data_wr_data,
    output logic                               tag_wr,
    output logic [ADDR_W-1:0]                  fill_addr,
    output logic [NUM_REQ-1:0]                 fill_done
);

    localparam int WIDX_W = clog2(WORDS_PER_BLOCK);
    localparam int CNT_W  = WIDX_W + 1;
    // Two bytes per word, so the byte offset inside a block is one bit wider than the word index
    localparam int OFF_W  = WIDX_W + 1;
    localparam logic [ADDR_W-1:0] BASE_MASK   = ~ADDR_W'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0]  BLOCK_WORDS = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);

    generate
        if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
            MEM_LATENCY < 1 || NUM_REQ < 1) begin : g_param_check
            $error("cache_fill_ctrl: illegal parameter combination");
        end
    endgenerate

    fill_state_e          state_reg, state_next;
    logic [CNT_W-1:0]     issue_cnt_reg, issue_cnt_next;
    logic [CNT_W-1:0]     recv_cnt_reg, recv_cnt_next;
    logic [ADDR_W-1:0]    base_reg, base_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [ADDR_W-1:0]    sel_addr;

    fixed_prio_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req   (miss_req),
        .grant (arb_grant)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            issue_cnt_reg <= '0;
            recv_cnt_reg  <= '0;
            base_reg      <= '0;
            grant_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            issue_cnt_reg <= issue_cnt_next;
            recv_cnt_reg  <= recv_cnt_next;
            base_reg      <= base_next;
            grant_reg     <= grant_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        recv_cnt_next  = recv_cnt_reg;
        base_next      = base_reg;
        grant_next     = grant_reg;
        mem_en         = 1'b0;
        mem_addr       = '0;
        data_wr        = 1'b0;
        data_wr_word   = '0;
        data_wr_data   = '0;
        tag_wr         = 1'b0;
        fill_done      = '0;

        case (state_reg)
            IDLE: begin
                if (|miss_req) begin
                    base_next      = sel_addr & BASE_MASK;
                    grant_next     = arb_grant;
                    issue_cnt_next = '0;
                    recv_cnt_next  = '0;
                    state_next     = FILL;
                end
            end
            FILL: begin
                if (issue_cnt_reg < BLOCK_WORDS) begin
                    mem_en         = 1'b1;
                    mem_addr       = base_reg + ADDR_W'({issue_cnt_reg, 1'b0});
                    issue_cnt_next = issue_cnt_reg + 1'b1;
                end
                // Returns arrive in issue order, so the receive count is the word index
                if (mem_data_valid) begin
                    data_wr       = 1'b1;
                    data_wr_word  = recv_cnt_reg[WIDX_W-1:0];
                    data_wr_data  = mem_data_in;
                    recv_cnt_next = recv_cnt_reg + 1'b1;
                    if (recv_cnt_reg == LAST_WORD) begin
                        tag_wr     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                fill_done  = grant_reg;
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant     = grant_reg;
    assign fill_addr = base_reg;
    assign stall     = (state_reg != IDLE) | (|miss_req);

endmodule
